// File: rtl/palette_lookup_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// palette_lookup_arbiter_pkg
// Shared types and constants for the sprite palette lookup path.
//   pal_index_t     : 4-bit palette index
//   rgb_t           : packed 24-bit colour {r, g, b}
//   TRANSPARENT_IDX : palette index reserved for the magenta key colour
//   NUM_LAYERS      : default number of pixel requesters sharing the palette
// ----------------------------------------------------------------------------
package palette_lookup_arbiter_pkg;

   typedef logic [3:0] pal_index_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam pal_index_t TRANSPARENT_IDX = 4'hF;
   localparam int         NUM_LAYERS      = 3;

endpackage

// File: rtl/palette_lookup_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search begins at 'ptr' and
// wraps from N-1 back to 0; the first asserted request wins. The pointer
// register itself lives in the parent so it only moves on a real transfer.
// Ports:
//   req    in  N      request vector
//   ptr    in  PTR_W  highest-priority requester for this cycle
//   grant  out N      one-hot grant (all zero when nothing requests)
//   winner out PTR_W  encoded index of the granted requester
//   any    out 1      at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N     = 3,
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] winner,
   output logic             any
);

   always_comb begin
      int idx;
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int k = 0; k < N; k++) begin
         // ptr is always < N, so one subtraction is enough to wrap
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            winner     = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// ----------------------------------------------------------------------------
// palette_lookup_arbiter
// Shares one combinational palette ROM between several pixel requesters.
// Stage S1 holds the granted index/tag/id and drives pal_index; stage S2
// registers the returned colour and presents it on a valid/ready port.
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake
//   req_index/req_tag       packed per-requester index and opaque tag
//   pal_index, pal_*        palette lookup (index out, RGB back combinationally)
//   resp_valid/resp_ready   response handshake
//   resp_id/tag/red/green/blue/transp   response payload
// ----------------------------------------------------------------------------
module palette_lookup_arbiter
   import palette_lookup_arbiter_pkg::*;
#(
   parameter  int               NUM_REQ         = NUM_LAYERS,
   parameter  int               IDX_W           = 4,
   parameter  int               TAG_W           = 10,
   parameter  logic [IDX_W-1:0] TRANSPARENT_IDX = IDX_W'(palette_lookup_arbiter_pkg::TRANSPARENT_IDX),
   localparam int               ID_W            = $clog2(NUM_REQ)
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*IDX_W-1:0] req_index,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic [IDX_W-1:0]         pal_index,
   input  logic [7:0]               pal_red,
   input  logic [7:0]               pal_green,
   input  logic [7:0]               pal_blue,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [ID_W-1:0]          resp_id,
   output logic [TAG_W-1:0]         resp_tag,
   output logic [7:0]               resp_red,
   output logic [7:0]               resp_green,
   output logic [7:0]               resp_blue,
   output logic                     resp_transp
);

   logic             s1_valid_q, s1_valid_d;
   logic [IDX_W-1:0] s1_index_q, s1_index_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
   logic [ID_W-1:0]  s1_id_q, s1_id_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic             resp_valid_q, resp_valid_d;
   logic [ID_W-1:0]  resp_id_q, resp_id_d;
   logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
   rgb_t             resp_rgb_q, resp_rgb_d;
   logic             resp_transp_q, resp_transp_d;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    winner;
   logic               any_req;
   logic               stall;
   logic               s1_adv;

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .req    (req_valid),
      .ptr    (rr_ptr_q),
      .grant  (grant),
      .winner (winner),
      .any    (any_req)
   );

   // S1 may take a new request when it is empty or when S2 is about to drain
   assign stall  = resp_valid_q & ~resp_ready;
   assign s1_adv = ~s1_valid_q | ~stall;

   // Ready is gated by reset so nothing is handed over while Reset_n is low
   assign req_ready = grant & {NUM_REQ{s1_adv & Reset_n}};

   // S1 capture and round-robin pointer update
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_index_d = s1_index_q;
      s1_tag_d   = s1_tag_q;
      s1_id_d    = s1_id_q;
      rr_ptr_d   = rr_ptr_q;
      if (s1_adv) begin
         s1_valid_d = any_req;
         if (any_req) begin
            s1_index_d = req_index[int'(winner)*IDX_W +: IDX_W];
            s1_tag_d   = req_tag[int'(winner)*TAG_W +: TAG_W];
            s1_id_d    = winner;
            rr_ptr_d   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
         end
      end
   end

   // S2 capture: the palette answers combinationally from S1's index
   always_comb begin
      resp_valid_d  = resp_valid_q;
      resp_id_d     = resp_id_q;
      resp_tag_d    = resp_tag_q;
      resp_rgb_d    = resp_rgb_q;
      resp_transp_d = resp_transp_q;
      if (!stall) begin
         resp_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            resp_id_d     = s1_id_q;
            resp_tag_d    = s1_tag_q;
            resp_rgb_d    = '{r: pal_red, g: pal_green, b: pal_blue};
            resp_transp_d = (s1_index_q == TRANSPARENT_IDX);
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_valid_q    <= 1'b0;
         s1_index_q    <= '0;
         s1_tag_q      <= '0;
         s1_id_q       <= '0;
         rr_ptr_q      <= '0;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= '0;
         resp_tag_q    <= '0;
         resp_rgb_q    <= '0;
         resp_transp_q <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_index_q    <= s1_index_d;
         s1_tag_q      <= s1_tag_d;
         s1_id_q       <= s1_id_d;
         rr_ptr_q      <= rr_ptr_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_tag_q    <= resp_tag_d;
         resp_rgb_q    <= resp_rgb_d;
         resp_transp_q <= resp_transp_d;
      end
   end

   assign pal_index   = s1_index_q;
   assign resp_valid  = resp_valid_q;
   assign resp_id     = resp_id_q;
   assign resp_tag    = resp_tag_q;
   assign resp_red    = resp_rgb_q.r;
   assign resp_green  = resp_rgb_q.g;
   assign resp_blue   = resp_rgb_q.b;
   assign resp_transp = resp_transp_q;

endmodule
